// File: rtl/bist_pkg.sv
// bist_pkg: shared types for the March C- BIST controller.
// State encoding, element indices and the per-element descriptor table.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN_A,
    RUN_B,
    DONE
  } state_t;

  localparam logic [2:0] M0 = 3'd0;
  localparam logic [2:0] M1 = 3'd1;
  localparam logic [2:0] M2 = 3'd2;
  localparam logic [2:0] M3 = 3'd3;
  localparam logic [2:0] M4 = 3'd4;
  localparam logic [2:0] M5 = 3'd5;

  typedef struct packed {
    logic down;
    logic rd_val;
    logic wr_val;
    logic has_read;
    logic has_write;
  } elem_desc_t;

  // Fields: down, rd_val, wr_val, has_read, has_write
  function automatic elem_desc_t elem_desc(
    input logic [2:0] e
  );
    elem_desc_t d;
    d = '0;
    unique case (e)
      M0: d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      M1: d = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      M2: d = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      M3: d = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      M4: d = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      M5: d = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bist_addr_cnt.sv
// bist_addr_cnt: up/down address counter with clear, preset-to-max,
// enable and terminal-count carry (carry = en at 0 (down) / max (up)).
module bist_addr_cnt #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              preset,
  input  logic              en,
  input  logic              down,
  output logic [ADDR_W-1:0] cnt,
  output logic              carry
);

  assign carry = en &
    (down ? (cnt == '0) : (cnt == '1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (preset) begin
      cnt <= '1;
    end else if (en) begin
      cnt <= down ? cnt - 1'b1 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bist_march_ctrl.sv
// bist_march_ctrl: March C- BIST controller for one sync single-port RAM.
// Ports: clk, rst (async active-low), start, mem_* RAM side, busy/done,
// fail, fail_addr, fail_elem; err_cnt exists only with BIST_DIAG_EN,
// which also makes a run continue past mismatches.
module bist_march_ctrl
  import bist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
`ifdef BIST_DIAG_EN
  ,
  output logic [ERR_W-1:0]  err_cnt
`endif
);

  state_t      state;
  logic [2:0]  elem;
  logic        go;
  logic        launch;
  elem_desc_t  desc;
  logic [DATA_W-1:0] exp_data;
  logic        step;
  logic        miss;
  logic        abort;
  logic        elem_end;
  logic        nxt_down;
  logic        cnt_clr;
  logic        cnt_preset;
  logic        cnt_en;
  logic        idle_like;

  assign idle_like = (state == IDLE) ||
                     (state == DONE);

  // start is captured one edge before the run begins, so the first
  // memory op lands one cycle after the sampling edge.
  assign launch = go && idle_like;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      go <= 1'b0;
    end else begin
      go <= start && idle_like && !go;
    end
  end

  always_comb begin
    desc      = elem_desc(elem);
    exp_data  = {DATA_W{desc.rd_val}};
    mem_re    = (state == RUN_A) && desc.has_read;
    mem_we    = ((state == RUN_A) && !desc.has_read) ||
                ((state == RUN_B) && desc.has_write);
    mem_wdata = mem_we ? {DATA_W{desc.wr_val}} : '0;
    step      = ((state == RUN_A) && !desc.has_read) ||
                (state == RUN_B);
    miss      = (state == RUN_B) &&
                (mem_rdata != exp_data);
    nxt_down  = elem_desc(elem + 3'd1).down;
  end

`ifdef BIST_DIAG_EN
  assign abort = 1'b0;
`else
  assign abort = miss;
`endif

  assign cnt_en     = step && !abort;
  assign cnt_clr    = launch || (elem_end && !nxt_down);
  assign cnt_preset = elem_end && nxt_down;

  bist_addr_cnt #(
    .ADDR_W (ADDR_W)
  ) u_addr_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .preset (cnt_preset),
    .en     (cnt_en),
    .down   (desc.down),
    .cnt    (mem_addr),
    .carry  (elem_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      elem      <= M0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (launch) begin
            state     <= RUN_A;
            elem      <= M0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
          end
        end
        RUN_A: begin
          if (desc.has_read) begin
            state <= RUN_B;
          end else if (elem_end) begin
            elem <= elem + 3'd1;
          end
        end
        RUN_B: begin
          if (abort) begin
            state <= DONE;
          end else if (elem_end) begin
            if (elem == M5) begin
              state <= DONE;
            end else begin
              elem  <= elem + 3'd1;
              state <= RUN_A;
            end
          end else begin
            state <= RUN_A;
          end
        end
        default: state <= IDLE;
      endcase
      if (miss && !fail) begin
        fail      <= 1'b1;
        fail_addr <= mem_addr;
        fail_elem <= elem;
      end
    end
  end

`ifdef BIST_DIAG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (launch) begin
      err_cnt <= '0;
    end else if (miss && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

  assign busy = (state == RUN_A) ||
                (state == RUN_B);
  assign done = (state == DONE);

endmodule
